// File: rtl/period_meter_if.sv
// ----------------------------------------------------------------------------
// period_meter_if
//   Bundles the measured signal, the enable and the measurement results of
//   period_meter into one interface.
//
//   Handshake: valid is a single-cycle strobe from the meter. It has no ready,
//   so it cannot be stalled. In the cycle valid is high, period, high_time and
//   overflow carry a new result. Those three hold their value until the next
//   strobe.
//
//   Signals:
//     sig_in    : measured signal (master -> meter)
//     enable    : level-sensitive measurement enable (master -> meter)
//     period    : clk cycles between the last two rising edges of sig_in
//     high_time : clk cycles sig_in was high within that period
//     valid     : one-cycle result strobe
//     overflow  : last reported period saturated at all-ones
//     busy      : meter is armed or measuring
//
//   Modports:
//     master : drives sig_in/enable and observes the results
//     slave  : the meter itself
// ----------------------------------------------------------------------------
interface period_meter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 sig_in;
    logic                 enable;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;
    logic                 valid;
    logic                 overflow;
    logic                 busy;

    modport master (
        output sig_in,
        output enable,
        input  period,
        input  high_time,
        input  valid,
        input  overflow,
        input  busy
    );

    modport slave (
        input  sig_in,
        input  enable,
        output period,
        output high_time,
        output valid,
        output overflow,
        output busy
    );
endinterface

// File: rtl/period_meter.sv
// ----------------------------------------------------------------------------
// period_meter
//   Measures the period and the high time of sig_in in clk cycles. The period
//   is taken between two successive rising edges. Both counters saturate at
//   all-ones. A saturated period is flagged through overflow.
//
//   Build option (macro PERIOD_METER_SYNC_EN):
//     defined   : sig_in passes through a two-flop synchronizer, so it may be
//                 asynchronous to clk.
//     undefined : sig_in is registered once and is assumed synchronous to clk.
//   The reported values are the same in both builds. Only the latency from
//   sig_in to valid changes.
//
//   Ports:
//     clk       : system clock, rising edge
//     reset     : asynchronous active-low reset
//     bus       : period_meter_if.slave (sig_in, enable -> period, high_time,
//                 valid, overflow, busy)
//     state_dbg : current FSM state (0 IDLE, 1 ARM, 2 MEASURE)
// ----------------------------------------------------------------------------
module period_meter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    period_meter_if.slave bus,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Input stage. sig_ok goes high once sig_s holds a real sample of
    // sig_in rather than a reset value.
    // ------------------------------------------------------------------
    logic sig_s;
    logic sig_ok;

`ifdef PERIOD_METER_SYNC_EN
    logic sig_meta;
    logic ok_meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_meta <= 1'b0;
            sig_s    <= 1'b0;
            ok_meta  <= 1'b0;
            sig_ok   <= 1'b0;
        end else begin
            sig_meta <= bus.sig_in;
            sig_s    <= sig_meta;
            ok_meta  <= 1'b1;
            sig_ok   <= ok_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_s  <= 1'b0;
            sig_ok <= 1'b0;
        end else begin
            sig_s  <= bus.sig_in;
            sig_ok <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Edge detector. seen_low makes sure that a signal already high when
    // reset is released does not count as a rising edge. An edge is only
    // accepted after sig_in has been sampled low at least once.
    // ------------------------------------------------------------------
    logic sig_prev;
    logic seen_low;
    logic rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_prev <= 1'b0;
            seen_low <= 1'b0;
        end else begin
            sig_prev <= sig_s;
            seen_low <= seen_low | (sig_ok & ~sig_s);
        end
    end

    assign rise = sig_s & ~sig_prev & seen_low;

    // ------------------------------------------------------------------
    // Measurement FSM. The rising edge that leaves ARM only starts the
    // count. Each later edge in MEASURE reports the count and restarts it.
    // Both counters load 1 on an edge because the edge cycle belongs to
    // the new period, and sig_s is high in that cycle.
    // ------------------------------------------------------------------
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] hcnt;
    logic [CNT_WIDTH-1:0] period_r;
    logic [CNT_WIDTH-1:0] high_r;
    logic                 ovf_r;
    logic                 valid_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hcnt     <= '0;
            period_r <= '0;
            high_r   <= '0;
            ovf_r    <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt  <= '0;
                    hcnt <= '0;
                    if (bus.enable) begin
                        state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!bus.enable) begin
                        state <= S_IDLE;
                    end else if (rise) begin
                        state <= S_MEASURE;
                        cnt   <= CNT_ONE;
                        hcnt  <= CNT_ONE;
                    end
                end
                S_MEASURE: begin
                    if (!bus.enable) begin
                        state <= S_IDLE;
                    end else if (rise) begin
                        period_r <= cnt;
                        high_r   <= hcnt;
                        ovf_r    <= (cnt == CNT_MAX);
                        valid_r  <= 1'b1;
                        cnt      <= CNT_ONE;
                        hcnt     <= CNT_ONE;
                    end else begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                        if (sig_s && (hcnt != CNT_MAX)) begin
                            hcnt <= hcnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.period    = period_r;
    assign bus.high_time = high_r;
    assign bus.overflow  = ovf_r;
    assign bus.valid     = valid_r;
    assign bus.busy      = (state == S_ARM) || (state == S_MEASURE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_period_meter.sv
// ----------------------------------------------------------------------------
// tb_period_meter
//   Testbench for period_meter with CNT_WIDTH = 8. Works with
//   PERIOD_METER_SYNC_EN defined or undefined.
//
//   The reference model watches sig_in cycle by cycle and keeps unbounded
//   integer counts. Each time it sees a rising edge that closes a period, it
//   pushes the expected {overflow, high_time, period} into exp_q. A separate
//   monitor pops exp_q whenever valid is high and compares the DUT outputs.
//
//   Stimulus changes enable only while sig_in has been stable for several
//   cycles. This keeps the result independent of the input-stage latency.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_period_meter;

    localparam int W       = 8;
    localparam int CNT_MAX = (1 << W) - 1;
    localparam int EW      = 2 * W + 1;

    // ------------------------------------------------------------------
    // Clock and reset
    // ------------------------------------------------------------------
    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    period_meter_if #(.CNT_WIDTH(W)) bus ();

    period_meter #(.CNT_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int            checks;
    int            errors;
    int            last_period;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. It works on the sig_in samples as the DUT sees
    // them at each rising clk edge.
    //   m_phase: 0 disabled, 1 waiting for first edge, 2 measuring
    // ------------------------------------------------------------------
    int m_phase;
    int m_len;
    int m_high;
    bit m_prev;
    bit m_seen_low;

    task automatic model_reset();
        m_phase    = 0;
        m_len      = 0;
        m_high     = 0;
        m_prev     = 1'b0;
        m_seen_low = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit en);
        bit rising;
        int p;
        int h;
        rising = s && !m_prev && m_seen_low;
        if (!en) begin
            m_phase = 0;
        end else begin
            if (m_phase == 0) m_phase = 1;
            if (rising) begin
                if (m_phase == 2) begin
                    p = (m_len  > CNT_MAX) ? CNT_MAX : m_len;
                    h = (m_high > CNT_MAX) ? CNT_MAX : m_high;
                    exp_q.push_back({(m_len >= CNT_MAX), h[W-1:0], p[W-1:0]});
                    last_period = p;
                end
                m_phase = 2;
                m_len   = 0;
                m_high  = 0;
            end
            if (m_phase == 2) begin
                m_len++;
                if (s) m_high++;
            end
        end
        if (!s) m_seen_low = 1'b1;
        m_prev = s;
    endtask

    // ------------------------------------------------------------------
    // Driver tasks. Inputs change on the falling edge. The model steps
    // with the value the DUT samples on the next rising edge.
    // ------------------------------------------------------------------
    task automatic drive(input bit s, input bit en);
        @(negedge clk);
        bus.sig_in = s;
        bus.enable = en;
        model_step(s, en);
    endtask

    task automatic wave(input int high, input int low, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < high; i++) drive(1'b1, 1'b1);
            for (int i = 0; i < low; i++)  drive(1'b0, 1'b1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},    int'(bus.period),    0);
        check({tag, "_high_time"}, int'(bus.high_time), 0);
        check({tag, "_valid"},     int'(bus.valid),     0);
        check({tag, "_overflow"},  int'(bus.overflow),  0);
        check({tag, "_busy"},      int'(bus.busy),      0);
        check({tag, "_state"},     int'(state_dbg),     0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pop and compare on every valid strobe
    // ------------------------------------------------------------------
    initial begin
        logic [EW-1:0] exp;
        forever begin
            @(negedge clk);
            if (reset && bus.valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 period=%0d expected no valid (t=%0t)",
                             bus.period, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("period",    int'(bus.period),    int'(exp[W-1:0]));
                    check("high_time", int'(bus.high_time), int'(exp[2*W-1:W]));
                    check("overflow",  int'(bus.overflow),  int'(exp[2*W]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int h;
        int l;
        int n;
        checks      = 0;
        errors      = 0;
        last_period = 0;
        model_reset();

        // Reset held low for 10 ns
        reset      = 1'b0;
        bus.sig_in = 1'b0;
        bus.enable = 1'b0;
        #7;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        model_step(1'b0, 1'b0);

        // sig_in toggled every 5 cycles: period 10, high_time 5
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
        wave(5, 5, 8);
        check("busy_measuring", int'(bus.busy), 1);

        // Divide-by-2: period 2, high_time 1
        wave(1, 1, 10);

        // Saturation: 300 high + 10 low gives 255 with overflow.
        // The next normal period clears overflow.
        wave(300, 10, 1);
        wave(5, 5, 3);

        // Enable dropped mid-period after a period of 10 was reported
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("disable_busy",   int'(bus.busy),   0);
        check("disable_period", int'(bus.period), last_period);
        check("disable_state",  int'(state_dbg),  0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0);
        check("disable_hold_period", int'(bus.period), 10);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
        wave(5, 5, 3);

        // Reset asserted 3 cycles before the next expected edge
        wave(5, 5, 2);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        bus.sig_in = 1'b1;
        bus.enable = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Release with sig_in already high and enable high
        reset = 1'b1;
        model_step(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        check("release_busy", int'(bus.busy), 1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
        wave(5, 5, 3);

        // Randomized periods, with enable sometimes cycled in between
        for (int t = 0; t < 8; t++) begin
            h = $urandom_range(1, 12);
            l = $urandom_range(1, 12);
            n = $urandom_range(2, 5);
            for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
                for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
            end
            wave(h, l, n);
        end

        // Drain outstanding results
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1);
        check("leftover_expected", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
